// File: rtl/mem_pkg.sv
// Shared types and the byte-merge helper for the simple-dual-port byte-enable memory.
// be_merge works on a fixed maximum width; callers size-cast in and out.
package mem_pkg;

    typedef enum logic {ST_INIT, ST_RUN} mem_state_t;

    localparam int unsigned MAX_W  = 256;
    localparam int unsigned MAX_BE = MAX_W / 8;

    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]  old_word,
        input logic [MAX_W-1:0]  new_word,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_be_array.sv
// Storage array with byte-enable write and combinational read; no reset.
module mem_be_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 24
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= DATA_W'(be_merge(MAX_W'(mem[waddr]), MAX_W'(wdata), MAX_BE'(wbe)));
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_sdp_be.sv
// Simple-dual-port memory: byte-enable writes, write-first bypass, 1- or 2-cycle reads,
// range flagging, and a clear sequence that zeroes the array after every reset.
module mem_sdp_be
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 24,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wren,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rden,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  ovalid,
    output logic                  rd_err,
    output logic                  wr_err,
    output logic                  init_busy
);

    localparam int unsigned BE_W = DATA_W / 8;

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
                else                             cnt_d   = cnt_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    assign run       = (state_q == ST_RUN);
    assign init_busy = (state_q == ST_INIT);

    // Extra bit so DEPTH == 2**ADDR_W compares correctly.
    logic wr_in_range, rd_in_range;
    assign wr_in_range = {1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH);
    assign rd_in_range = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [BE_W-1:0]   arr_wbe;
    logic [ADDR_W-1:0] arr_raddr;
    logic [DATA_W-1:0] arr_rdata;

    always_comb begin
        if (init_busy) begin
            arr_we    = 1'b1;
            arr_waddr = cnt_q;
            arr_wdata = '0;
            arr_wbe   = '1;
        end else begin
            arr_we    = wren & wr_in_range;
            arr_waddr = wr_addr;
            arr_wdata = wr_data;
            arr_wbe   = wr_be;
        end
        arr_raddr = rd_in_range ? rd_addr : '0;
    end

    mem_be_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .wbe    (arr_wbe),
        .raddr  (arr_raddr),
        .rdata  (arr_rdata)
    );

    // Write-first: a same-cycle write to the read address is merged into the returned word.
    logic              byp_hit;
    logic              rd_acc;
    logic              rd_bad;
    logic [DATA_W-1:0] s0_data;

    always_comb begin
        byp_hit = run & wren & wr_in_range & (wr_addr == rd_addr);
        rd_acc  = run & rden;
        rd_bad  = ~rd_in_range;
        if (!rd_in_range) begin
            s0_data = '0;
        end else if (byp_hit) begin
            s0_data = DATA_W'(be_merge(MAX_W'(arr_rdata), MAX_W'(wr_data), MAX_BE'(wr_be)));
        end else begin
            s0_data = arr_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err <= 1'b0;
        else        wr_err <= run & wren & ~wr_in_range;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v1_q;
            logic              e1_q;
            logic [DATA_W-1:0] d1_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v1_q    <= 1'b0;
                    e1_q    <= 1'b0;
                    d1_q    <= '0;
                    ovalid  <= 1'b0;
                    rd_err  <= 1'b0;
                    rd_data <= '0;
                end else begin
                    v1_q   <= rd_acc;
                    e1_q   <= rd_acc & rd_bad;
                    if (rd_acc) d1_q <= s0_data;
                    ovalid <= v1_q;
                    rd_err <= v1_q & e1_q;
                    if (v1_q) rd_data <= d1_q;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovalid  <= 1'b0;
                    rd_err  <= 1'b0;
                    rd_data <= '0;
                end else begin
                    ovalid <= rd_acc;
                    rd_err <= rd_acc & rd_bad;
                    if (rd_acc) rd_data <= s0_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mem_sdp_be.sv
// Directed bench for mem_sdp_be: one instance per read latency, driven by the same stimulus.
module tb_mem_sdp_be;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wren;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rden;
    logic [4:0]  rd_addr;

    logic [31:0] rd_data1, rd_data2;
    logic        ovalid1, ovalid2;
    logic        rd_err1, rd_err2;
    logic        wr_err1, wr_err2;
    logic        init_busy1, init_busy2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_sdp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .RD_LAT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wren      (wren),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rden      (rden),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data1),
        .ovalid    (ovalid1),
        .rd_err    (rd_err1),
        .wr_err    (wr_err1),
        .init_busy (init_busy1)
    );

    mem_sdp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .RD_LAT(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wren      (wren),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rden      (rden),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data2),
        .ovalid    (ovalid2),
        .rd_err    (rd_err2),
        .wr_err    (wr_err2),
        .init_busy (init_busy2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wren = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wren = 1'b0;
    endtask

    // Single read checked on both instances, including the one-cycle ovalid pulse.
    task automatic rd_expect(input string tag, input logic [4:0] a, input logic [31:0] d,
                             input logic err);
        rden = 1'b1; rd_addr = a;
        tick();
        rden = 1'b0;
        check_eq({tag, "_v1"}, 32'(ovalid1), 32'd1);
        check_eq({tag, "_d1"}, rd_data1, d);
        check_eq({tag, "_e1"}, 32'(rd_err1), 32'(err));
        check_eq({tag, "_v2_early"}, 32'(ovalid2), 32'd0);
        tick();
        check_eq({tag, "_v1_off"}, 32'(ovalid1), 32'd0);
        check_eq({tag, "_e1_off"}, 32'(rd_err1), 32'd0);
        check_eq({tag, "_v2"}, 32'(ovalid2), 32'd1);
        check_eq({tag, "_d2"}, rd_data2, d);
        check_eq({tag, "_e2"}, 32'(rd_err2), 32'(err));
    endtask

    initial begin
        logic ov_seen;
        int   wait_cnt;

        rst_n = 1'b1; wren = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rden = 1'b1; rd_addr = 5'd3;
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_rd_data1", rd_data1, 32'd0);
        check_eq("rst_ovalid1", 32'(ovalid1), 32'd0);
        check_eq("rst_rd_err1", 32'(rd_err1), 32'd0);
        check_eq("rst_wr_err1", 32'(wr_err1), 32'd0);
        check_eq("rst_busy1", 32'(init_busy1), 32'd1);
        check_eq("rst_ovalid2", 32'(ovalid2), 32'd0);
        check_eq("rst_busy2", 32'(init_busy2), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        // Clear sequence with a read held on address 3
        ov_seen = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick();
            ov_seen = ov_seen | ovalid1 | ovalid2;
            if (k == 22) check_eq("busy_at_R0+22", 32'(init_busy1), 32'd1);
            if (k == 23) begin
                check_eq("busy_fall1", 32'(init_busy1), 32'd0);
                check_eq("busy_fall2", 32'(init_busy2), 32'd0);
            end
        end
        check_eq("no_ovalid_in_init", 32'(ov_seen), 32'd0);
        tick();
        rden = 1'b0;
        check_eq("first_v1", 32'(ovalid1), 32'd1);
        check_eq("first_d1", rd_data1, 32'd0);
        check_eq("first_v2_early", 32'(ovalid2), 32'd0);
        tick();
        check_eq("first_v2", 32'(ovalid2), 32'd1);
        check_eq("first_d2", rd_data2, 32'd0);
        check_eq("first_v1_off", 32'(ovalid1), 32'd0);
        tick();
        tick();

        // Byte enables
        wr(5'd5, 32'hAABBCCDD, 4'hF);
        wr(5'd5, 32'h11223344, 4'b0101);
        rd_expect("be_merge", 5'd5, 32'hAA22CC44, 1'b0);
        wr(5'd5, 32'h00000000, 4'b0000);
        check_eq("be_zero_no_err", 32'(wr_err1), 32'd0);
        rd_expect("be_zero", 5'd5, 32'hAA22CC44, 1'b0);

        // Write-first bypass on address 7
        wren = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b1100;
        rden = 1'b1; rd_addr = 5'd7;
        tick();
        wren = 1'b0; rden = 1'b0;
        check_eq("byp_v1", 32'(ovalid1), 32'd1);
        check_eq("byp_d1", rd_data1, 32'hDEAD0000);
        tick();
        check_eq("byp_v2", 32'(ovalid2), 32'd1);
        check_eq("byp_d2", rd_data2, 32'hDEAD0000);
        rd_expect("byp_stored", 5'd7, 32'hDEAD0000, 1'b0);

        // Out of range
        wr(5'd30, 32'hFFFFFFFF, 4'hF);
        check_eq("wr_err1_hi", 32'(wr_err1), 32'd1);
        check_eq("wr_err2_hi", 32'(wr_err2), 32'd1);
        tick();
        check_eq("wr_err1_lo", 32'(wr_err1), 32'd0);
        rd_expect("oor_rd", 5'd30, 32'd0, 1'b1);
        rd_expect("oor_alias6", 5'd6, 32'd0, 1'b0);
        rd_expect("oor_top23", 5'd23, 32'd0, 1'b0);
        rd_expect("oor_keep5", 5'd5, 32'hAA22CC44, 1'b0);

        // Streaming reads
        wr(5'd0, 32'h10, 4'hF);
        wr(5'd1, 32'h11, 4'hF);
        wr(5'd2, 32'h12, 4'hF);
        rden = 1'b1; rd_addr = 5'd0;
        tick();
        check_eq("st_d1_0", rd_data1, 32'h10);
        check_eq("st_v2_early", 32'(ovalid2), 32'd0);
        rd_addr = 5'd1;
        tick();
        check_eq("st_d1_1", rd_data1, 32'h11);
        check_eq("st_v2_0", 32'(ovalid2), 32'd1);
        check_eq("st_d2_0", rd_data2, 32'h10);
        rd_addr = 5'd2;
        tick();
        rden = 1'b0;
        check_eq("st_d1_2", rd_data1, 32'h12);
        check_eq("st_v2_1", 32'(ovalid2), 32'd1);
        check_eq("st_d2_1", rd_data2, 32'h11);
        tick();
        check_eq("st_v1_off", 32'(ovalid1), 32'd0);
        check_eq("st_d1_hold", rd_data1, 32'h12);
        check_eq("st_v2_2", 32'(ovalid2), 32'd1);
        check_eq("st_d2_2", rd_data2, 32'h12);
        tick();
        check_eq("st_v2_off", 32'(ovalid2), 32'd0);
        check_eq("st_d2_hold", rd_data2, 32'h12);

        // Latency-2 word is captured at stage 1; next-cycle write is not seen
        rden = 1'b1; rd_addr = 5'd0;
        tick();
        rden = 1'b0;
        wren = 1'b1; wr_addr = 5'd0; wr_data = 32'h99; wr_be = 4'hF;
        tick();
        wren = 1'b0;
        check_eq("cap_v2", 32'(ovalid2), 32'd1);
        check_eq("cap_d2", rd_data2, 32'h10);
        rd_expect("cap_after", 5'd0, 32'h99, 1'b0);

        // Reset with reads in flight
        rden = 1'b1; rd_addr = 5'd5;
        tick();
        rd_addr = 5'd7;
        tick();
        #2 rst_n = 1'b0;
        #1;
        rden = 1'b0;
        check_eq("mid_rst_v1", 32'(ovalid1), 32'd0);
        check_eq("mid_rst_v2", 32'(ovalid2), 32'd0);
        check_eq("mid_rst_d2", rd_data2, 32'd0);
        check_eq("mid_rst_busy", 32'(init_busy2), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        ov_seen = 1'b0;
        wait_cnt = 0;
        while (init_busy1 && wait_cnt < 40) begin
            tick();
            ov_seen = ov_seen | ovalid1 | ovalid2;
            wait_cnt++;
        end
        check_eq("reinit_done", 32'(init_busy1), 32'd0);
        check_eq("reinit_cycles", 32'(wait_cnt), 32'd24);
        check_eq("no_late_ovalid", 32'(ov_seen), 32'd0);
        rd_expect("reinit_5", 5'd5, 32'd0, 1'b0);
        rd_expect("reinit_7", 5'd7, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
